pwm_sample_scheduler: RTL and testbench
=======================================

// Module: pwm_sample_scheduler
// PURPOSE
//  Paces audio samples into the PWM output stage at exactly one sample per PWM frame.
//  Accepts signed samples from the filter chain over a valid/ready handshake.
//  Buffers them in a small FIFO, converts each to offset-binary, and drives the PWM duty input.
//  Handles start-up priming, underrun recovery and mute. Sits between the filter output and the PWM block.
// PARAMETERS
//  N      10  PWM duty width; must match the PWM stage's N
//  W      16  input sample width (two's complement), W >= N
//  DEPTH  4   FIFO depth in samples, power of 2, >= 2
// PORTS
//  clk          in   1           system clock
//  reset_n      in   1           asynchronous, active-low reset
//  s_valid      in   1           upstream sample valid
//  s_data       in   W           signed sample
//  s_ready      out  1           FIFO can accept (= !full)
//  pwm_ready    in   1           from PWM stage; high in second half of each frame
//  mute         in   1           force midscale output
//  duty_val     out  N           duty code to PWM stage (registered)
//  frame_tick   out  1           one-cycle pulse per PWM frame
//  underrun     out  1           one-cycle pulse when a tick finds the FIFO empty in PLAY
//  underrun_cnt out  16          saturating underrun count
//  fifo_level   out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset values:
//   - duty_val = 2^(N-1) (midscale).
//   - frame_tick = 0, underrun = 0, underrun_cnt = 0.
//   - FIFO empty, fifo_level = 0, s_ready = 1.
//   - State = PRIME. pwm_ready_d = 0.
//  Frame detect:
//   - pwm_ready_d <= pwm_ready.
//   - frame_tick = pwm_ready & ~pwm_ready_d (combinational, cycle T).
//   - All tick actions are registered at the end of T and visible at T+1.
//   - The PWM stage latches duty_val at its count wrap, about half a frame later.
//  Push:
//   - A sample is written when s_valid & s_ready. s_ready = (fifo_level != DEPTH).
//   - s_data is held by upstream until accepted.
//  Conversion: code = {~s_data[W-1], s_data[W-2 -: N-1]}.
//   - This is the top N bits with the MSB inverted.
//   - Examples: 0x8000 -> 0x000; 0x0000 -> 0x200; 0x7FFF -> 0x3FF (W=16, N=10).
//  FSM:
//   - PRIME:
//     - duty_val is held at midscale and no pops occur.
//     - On a tick with fifo_level >= DEPTH/2: pop, load duty_val, go to PLAY.
//   - PLAY, on tick with FIFO non-empty:
//     - Pop.
//     - duty_val <= mute ? 2^(N-1) : code.
//   - PLAY, on tick with FIFO empty:
//     - underrun pulses for 1 cycle.
//     - underrun_cnt increments, saturating at 0xFFFF.
//     - duty_val holds its last value. Go to PRIME.
//  Mute:
//   - Sampled only at tick. Muted samples are still popped and discarded, so stream timing is kept.
//   - Unmuting takes effect at the next tick.
//  Simultaneous events:
//   - Push and pop in the same cycle: the level is unchanged, and the popped entry is the oldest.
//   - Push in the same cycle as a tick on an empty FIFO: this counts as an underrun (decided on the registered level). The push is still accepted, so level = 1 afterwards.
//   - Full FIFO with a tick in the same cycle: s_ready is still 0 in that cycle. It rises the cycle after the pop.
//   - underrun_cnt saturates and does not wrap. FIFO pointers wrap modulo DEPTH.
//  Reset mid-operation:
//   - All state returns to reset values immediately (asynchronously).
//   - FIFO contents are discarded. The PWM stage sees midscale from the next frame onward.
// TESTING
//  1 Reset, toggle pwm_ready for 3 frames with no samples -> duty_val=0x200, underrun never pulses, state stays PRIME.
//  2 Push 0x8000 and 0x7FFF (DEPTH=4), then ticks -> tick1: duty 0x000; tick2: duty 0x3FF; tick3: underrun=1, cnt=1, duty stays 0x3FF.
//  3 Push 6 samples back-to-back with no ticks -> s_ready=0 after 4, level=4. After a tick, level=3 and s_ready=1 the next cycle.
//  4 Assert mute during PLAY with 0x4000 queued -> duty 0x200 at that tick, level decrements. Release mute -> next sample's code appears.
//  5 Push on the same cycle as a tick with level=0 in PLAY -> underrun pulse, level=1, state PRIME.
//  6 Drop reset_n mid-PLAY with level=3 -> same cycle: duty_val=0x200, level=0, underrun_cnt=0. After release, PRIME behaviour resumes.

Source files
------------

// File: rtl/pwm_sample_scheduler_if.sv
// Sample stream from the filter chain into the PWM scheduler.
// Upstream holds s_data stable while s_valid is high until s_ready accepts it.
interface pwm_sample_scheduler_if #(
   parameter int W = 16
);
   logic         s_valid;
   logic [W-1:0] s_data;
   logic         s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/pwm_sample_scheduler.sv
// Paces buffered audio samples into the PWM duty input at one sample per PWM frame,
// with start-up priming, underrun recovery and mute.
module pwm_sample_scheduler #(
   parameter int N     = 10,
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   pwm_sample_scheduler_if.slave    s,
   input  logic                     pwm_ready,
   input  logic                     mute,
   output logic [N-1:0]             duty_val,
   output logic                     frame_tick,
   output logic                     underrun,
   output logic [15:0]              underrun_cnt,
   output logic [$clog2(DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [N-1:0] MID = {1'b1, {(N-1){1'b0}}};

   typedef enum logic {PRIME, PLAY} state_t;

   state_t         state;
   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           pwm_ready_d;
   logic           push;
   logic           pop;
   logic           empty;
   logic [W-1:0]   head;
   logic [N-1:0]   code;

   assign s.s_ready  = (fifo_level != LW'(DEPTH));
   assign frame_tick = pwm_ready & ~pwm_ready_d;
   assign push       = s.s_valid & s.s_ready;
   assign empty      = (fifo_level == '0);
   // PRIME only pops once half the FIFO is filled, giving slack against jitter upstream
   assign pop        = frame_tick & ~empty & ((state == PLAY) | (fifo_level >= LW'(DEPTH / 2)));
   assign head       = mem[rd_ptr];
   assign code       = {~head[W-1], head[W-2 -: N-1]};

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= s.s_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fifo_level <= fifo_level + LW'(push) - LW'(pop);
      end
   end

   // Underrun is decided on the registered level, so a push in the tick cycle cannot rescue it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= PRIME;
         duty_val     <= MID;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
         pwm_ready_d  <= 1'b0;
      end else begin
         pwm_ready_d <= pwm_ready;
         underrun    <= 1'b0;
         if (frame_tick) begin
            case (state)
               PRIME: begin
                  if (pop) begin
                     duty_val <= mute ? MID : code;
                     state    <= PLAY;
                  end
               end
               PLAY: begin
                  if (pop) begin
                     duty_val <= mute ? MID : code;
                  end else begin
                     underrun <= 1'b1;
                     if (underrun_cnt != 16'hFFFF) begin
                        underrun_cnt <= underrun_cnt + 16'd1;
                     end
                     state <= PRIME;
                  end
               end
               default: state <= PRIME;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Self-checking bench: directed scenarios plus a randomized run, all compared
// against a queue-based reference model of the scheduler.
module tb_pwm_sample_scheduler;
   localparam int N     = 10;
   localparam int W     = 16;
   localparam int DEPTH = 4;
   localparam int MIDV  = 1 << (N - 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pwm_ready = 1'b0;
   logic          mute = 1'b0;
   logic [N-1:0]  duty_val;
   logic          frame_tick;
   logic          underrun;
   logic [15:0]   underrun_cnt;
   logic [$clog2(DEPTH):0] fifo_level;

   pwm_sample_scheduler_if #(.W(W)) bus ();

   pwm_sample_scheduler #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s            (bus.slave),
      .pwm_ready    (pwm_ready),
      .mute         (mute),
      .duty_val     (duty_val),
      .frame_tick   (frame_tick),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .fifo_level   (fifo_level)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   int q[$];
   int m_duty;
   int m_cnt;
   bit m_prime;
   bit m_pwm_d;
   bit m_underrun;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Offset-binary duty: shift the signed range up to unsigned, keep the top N bits
   function automatic int toDuty(input logic [W-1:0] d);
      int v;
      v = int'($signed(d));
      return (v + (1 << (W - 1))) >> (W - N);
   endfunction

   task automatic modelReset();
      q.delete();
      m_duty     = MIDV;
      m_cnt      = 0;
      m_prime    = 1'b1;
      m_pwm_d    = 1'b0;
      m_underrun = 1'b0;
   endtask

   task automatic applyStimulus(input bit pr, input bit v, input logic [W-1:0] d, input bit m,
                                output bit accepted);
      bit tick;
      int smp;
      @(negedge clk);
      pwm_ready   = pr;
      bus.s_valid = v;
      bus.s_data  = d;
      mute        = m;
      #1;
      tick = pr && !m_pwm_d;
      checkOutput("frame_tick", 32'(frame_tick), 32'(tick));
      checkOutput("s_ready", 32'(bus.s_ready), 32'(q.size() != DEPTH));
      checkOutput("fifo_level", 32'(fifo_level), 32'(q.size()));
      checkOutput("duty_val", 32'(duty_val), 32'(m_duty));
      checkOutput("underrun", 32'(underrun), 32'(m_underrun));
      checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
      accepted   = v && (q.size() < DEPTH);
      m_underrun = 1'b0;
      if (tick) begin
         if (m_prime) begin
            if (q.size() >= DEPTH / 2) begin
               smp     = q.pop_front();
               m_duty  = m ? MIDV : toDuty(W'(smp));
               m_prime = 1'b0;
            end
         end else if (q.size() > 0) begin
            smp    = q.pop_front();
            m_duty = m ? MIDV : toDuty(W'(smp));
         end else begin
            m_underrun = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            m_prime = 1'b1;
         end
      end
      if (accepted) q.push_back(int'(d));
      m_pwm_d = pr;
   endtask

   task automatic step(input bit pr, input bit v, input logic [W-1:0] d, input bit m);
      bit acc;
      applyStimulus(pr, v, d, m, acc);
   endtask

   // Low half then rising high half: the second cycle carries the frame tick
   task automatic frame(input bit m);
      step(1'b0, 1'b0, '0, m);
      step(1'b1, 1'b0, '0, m);
   endtask

   task automatic doReset();
      @(negedge clk);
      reset_n     = 1'b0;
      bus.s_valid = 1'b0;
      pwm_ready   = 1'b0;
      #1;
      checkOutput("rst_duty", 32'(duty_val), 32'(MIDV));
      checkOutput("rst_level", 32'(fifo_level), 32'd0);
      checkOutput("rst_cnt", 32'(underrun_cnt), 32'd0);
      checkOutput("rst_underrun", 32'(underrun), 32'd0);
      checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);
      modelReset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      bit acc;
      bit pending;
      logic [W-1:0] data;
      int fcnt;
      int flen;
      int pval;
      bit m;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      modelReset();
      doReset();

      // Idle frames without samples stay primed at midscale
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 3; c++) step(1'b0, 1'b0, '0, 1'b0);
         for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0, 1'b0);
      end
      checkOutput("t1_duty", 32'(duty_val), 32'h200);
      checkOutput("t1_cnt", 32'(underrun_cnt), 32'd0);

      // Extremes of the sample range, then an underrun
      step(1'b0, 1'b1, 16'h8000, 1'b0);
      step(1'b0, 1'b1, 16'h7FFF, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t2_duty1", 32'(duty_val), 32'h000);
      frame(1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t2_duty2", 32'(duty_val), 32'h3FF);
      frame(1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t2_underrun", 32'(underrun), 32'd1);
      checkOutput("t2_cnt", 32'(underrun_cnt), 32'd1);
      checkOutput("t2_duty3", 32'(duty_val), 32'h3FF);

      // Overfill with no ticks, then one tick while upstream keeps pushing
      data = 16'h1000;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b1, data, 1'b0, acc);
         if (acc) data = data + 16'h1000;
      end
      checkOutput("t3_level_full", 32'(fifo_level), 32'd4);
      checkOutput("t3_ready_full", 32'(bus.s_ready), 32'd0);
      step(1'b1, 1'b1, data, 1'b0);
      checkOutput("t3_ready_tick", 32'(bus.s_ready), 32'd0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t3_level_after", 32'(fifo_level), 32'd3);
      checkOutput("t3_ready_after", 32'(bus.s_ready), 32'd1);

      // Mute during PLAY discards a sample; unmute shows the next one
      doReset();
      step(1'b0, 1'b1, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 16'h4000, 1'b0);
      step(1'b0, 1'b1, 16'hC000, 1'b0);
      frame(1'b0);
      frame(1'b1);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t4_mute_duty", 32'(duty_val), 32'h200);
      checkOutput("t4_mute_level", 32'(fifo_level), 32'd1);
      frame(1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t4_unmute_duty", 32'(duty_val), 32'h100);

      // Push on the same cycle as an underrunning tick
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b1, 16'h1111, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t5_underrun", 32'(underrun), 32'd1);
      checkOutput("t5_level", 32'(fifo_level), 32'd1);
      frame(1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t5_prime_level", 32'(fifo_level), 32'd1);
      checkOutput("t5_prime_underrun", 32'(underrun), 32'd0);

      // Reach PLAY with three queued, then reset asynchronously
      step(1'b0, 1'b1, 16'h2222, 1'b0);
      step(1'b1, 1'b1, 16'h3333, 1'b0);
      step(1'b0, 1'b1, 16'h4444, 1'b0);
      step(1'b0, 1'b1, 16'h5555, 1'b0);
      checkOutput("t6_level", 32'(fifo_level), 32'd3);
      doReset();
      frame(1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      checkOutput("t6_prime_underrun", 32'(underrun), 32'd0);
      checkOutput("t6_prime_duty", 32'(duty_val), 32'h200);

      // Randomized traffic with irregular frame lengths
      pending = 1'b0;
      data    = '0;
      fcnt    = 0;
      flen    = 6;
      pval    = 50;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 200 == 0) pval = $urandom_range(15, 95);
         if (fcnt >= flen) begin
            fcnt = 0;
            flen = $urandom_range(2, 10);
         end
         if (!pending) begin
            pending = ($urandom % 100) < pval;
            data    = W'($urandom);
         end
         m = !m_prime && (($urandom % 4) == 0);
         applyStimulus(fcnt >= flen / 2, pending, data, m, acc);
         if (acc) pending = 1'b0;
         fcnt++;
      end
      bus.s_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
